// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
// Central hazard/stall controller for the 5-stage LC-3b pipeline.
// Merges icache, dcache, divide/multiply and load-use stalls plus the
// MEM-stage branch flush into per-register load/bubble enables. It also
// keeps a registered stall-class FSM and a sticky stall watchdog.
//
// Optional build macro: STALL_PERF_CNT_EN adds perf_ex_cycles and
// perf_mem_cycles, which are free-running EX_WAIT / MEM_WAIT cycle counters.
//
// Handshake with the divide/multiply unit: stall_X=1 means the unit is busy.
// flow_X=1 means the unit may complete in this cycle. flow_X never depends
// on stall_X, so the unit may drop stall_X combinationally in a flow_X=1
// cycle without forming a loop. When it does, the class falls through to
// the lower priorities in the same cycle. kill_X=1 aborts any operation in
// progress, and the unit returns to idle.
module pipeline_stall_ctrl #(
  parameter int WD_LIMIT = 1024,
  parameter int WD_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       icache_stall,
  input  logic       dcache_stall,
  input  logic       stall_X,
  input  logic       flush_req,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [2:0] ex_dr,
  input  logic       id_use_sr1,
  input  logic       id_use_sr2,
  input  logic [2:0] id_sr1,
  input  logic [2:0] id_sr2,
  output logic       ld_pc,
  output logic       ld_if_id,
  output logic       ld_id_ex,
  output logic       ld_ex_mem,
  output logic       ld_mem_wb,
  output logic       bub_if_id,
  output logic       bub_id_ex,
  output logic       bub_ex_mem,
  output logic       flow_X,
  output logic       kill_X,
  output logic [2:0] stall_class,
  output logic       stall_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_ex_cycles,
  output logic [31:0] perf_mem_cycles
`endif
);

  localparam logic [2:0] CLS_RUN      = 3'd0;
  localparam logic [2:0] CLS_IF_WAIT  = 3'd1;
  localparam logic [2:0] CLS_HAZ      = 3'd2;
  localparam logic [2:0] CLS_EX_WAIT  = 3'd3;
  localparam logic [2:0] CLS_MEM_WAIT = 3'd4;
  localparam logic [2:0] CLS_FLUSH    = 3'd5;

  logic            load_use;
  logic [2:0]      cur_class;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_next;

  assign load_use = ex_valid & ex_is_load &
                    ((id_use_sr1 & (id_sr1 == ex_dr)) |
                     (id_use_sr2 & (id_sr2 == ex_dr)));

  // The divide unit may complete whenever MEM is not frozen and no flush is pending.
  assign flow_X = ~dcache_stall & ~flush_req;

  // Select the stall class of this cycle by strict priority.
  always_comb begin
    cur_class = CLS_RUN;
    if (dcache_stall)      cur_class = CLS_MEM_WAIT;
    else if (flush_req)    cur_class = CLS_FLUSH;
    else if (stall_X)      cur_class = CLS_EX_WAIT;
    else if (load_use)     cur_class = CLS_HAZ;
    else if (icache_stall) cur_class = CLS_IF_WAIT;
  end

  // Decode the class into register load, bubble and kill enables.
  always_comb begin
    ld_pc      = 1'b0;
    ld_if_id   = 1'b0;
    ld_id_ex   = 1'b0;
    ld_ex_mem  = 1'b0;
    ld_mem_wb  = 1'b0;
    bub_if_id  = 1'b0;
    bub_id_ex  = 1'b0;
    bub_ex_mem = 1'b0;
    kill_X     = 1'b0;
    case (cur_class)
      CLS_RUN: begin
        ld_pc     = 1'b1;
        ld_if_id  = 1'b1;
        ld_id_ex  = 1'b1;
        ld_ex_mem = 1'b1;
        ld_mem_wb = 1'b1;
      end
      CLS_FLUSH: begin
        // The redirect must land even when the fetch side is stalled.
        ld_pc      = 1'b1;
        ld_if_id   = 1'b1;
        ld_id_ex   = 1'b1;
        ld_ex_mem  = 1'b1;
        ld_mem_wb  = 1'b1;
        bub_if_id  = 1'b1;
        bub_id_ex  = 1'b1;
        bub_ex_mem = 1'b1;
        kill_X     = 1'b1;
      end
      CLS_EX_WAIT: begin
        ld_ex_mem  = 1'b1;
        ld_mem_wb  = 1'b1;
        bub_ex_mem = 1'b1;
      end
      CLS_HAZ: begin
        ld_id_ex  = 1'b1;
        bub_id_ex = 1'b1;
        ld_ex_mem = 1'b1;
        ld_mem_wb = 1'b1;
      end
      CLS_IF_WAIT: begin
        ld_if_id  = 1'b1;
        bub_if_id = 1'b1;
        ld_id_ex  = 1'b1;
        ld_ex_mem = 1'b1;
        ld_mem_wb = 1'b1;
      end
      default: begin
        // MEM_WAIT: everything holds.
      end
    endcase
  end

  // Next watchdog count: clear on progress, otherwise saturating increment.
  always_comb begin
    wd_next = wd_cnt;
    if (cur_class == CLS_RUN || cur_class == CLS_FLUSH) wd_next = '0;
    else if (!(&wd_cnt))                                wd_next = wd_cnt + WD_W'(1);
  end

  // Register the stall class, the watchdog count and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_class   <= CLS_RUN;
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_class <= cur_class;
      wd_cnt      <= wd_next;
      if (wd_next >= WD_W'(WD_LIMIT)) stall_timeout <= 1'b1;
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Count EX_WAIT and MEM_WAIT cycles; these counters wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ex_cycles  <= '0;
      perf_mem_cycles <= '0;
    end else begin
      if (cur_class == CLS_EX_WAIT)  perf_ex_cycles  <= perf_ex_cycles + 32'd1;
      if (cur_class == CLS_MEM_WAIT) perf_mem_cycles <= perf_mem_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central hazard/stall controller for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Merges the stall sources: the icache, the dcache, the multi-cycle EX divide/multiply unit and the load-use hazard. Also merges the MEM-stage branch flush.
- Drives per-register load and bubble enables, plus the flow_X release and kill_X abort signals sent back to the EX divide/multiply unit.
- Contains a registered stall-class FSM and a stall watchdog.

Parameters:
- WD_LIMIT, 1024: count of consecutive stalled cycles at which stall_timeout sets.
- WD_W, 16: watchdog counter width. WD_LIMIT must be less than 2^WD_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- icache_stall  input  1  instruction fetch not ready.
- dcache_stall  input  1  MEM-stage data access not ready.
- stall_X  input  1  divide/multiply unit busy. It may fall combinationally in the same cycle flow_X=1.
- flush_req  input  1  branch taken, resolved in MEM.
- ex_valid  input  1  EX holds a real instruction.
- ex_is_load  input  1  instruction in EX is LDR/LDB/LDI.
- ex_dr  input  3  destination register of the instruction in EX.
- id_use_sr1, id_use_sr2  input  1  instruction in ID reads sr1 / sr2.
- id_sr1, id_sr2  input  3  source register numbers of the instruction in ID.
- ld_pc, ld_if_id, ld_id_ex, ld_ex_mem, ld_mem_wb  output  1  register load enables.
- bub_if_id, bub_id_ex, bub_ex_mem  output  1  load a NOP instead of upstream data. Meaningful only when the matching ld is 1.
- flow_X  output  1  divide/multiply unit may complete and release the pipeline.
- kill_X  output  1  abort any divide/multiply in progress; the unit returns to its idle state.
- stall_class  output  3  registered class of the previous cycle.
- stall_timeout  output  1  sticky watchdog flag.

Behaviour:
- Combinational class of the current cycle, strict priority order:
  - MEM_WAIT (dcache_stall)
  - FLUSH (flush_req)
  - EX_WAIT (stall_X)
  - HAZ (load-use)
  - IF_WAIT (icache_stall)
  - RUN
- Load-use is true when ex_valid & ex_is_load & ((id_use_sr1 & id_sr1==ex_dr) | (id_use_sr2 & id_sr2==ex_dr)).
- Outputs per class (every ld/bub not listed is 0):
  - RUN: all ld=1.
  - MEM_WAIT: all ld=0; nothing moves.
  - FLUSH: all ld=1; bub_if_id=bub_id_ex=bub_ex_mem=1; kill_X=1. ld_pc=1 even while icache_stall is high.
  - EX_WAIT: ld_mem_wb=1, ld_ex_mem=1, bub_ex_mem=1; ld_pc=ld_if_id=ld_id_ex=0.
  - HAZ: ld_pc=ld_if_id=0; ld_id_ex=1 with bub_id_ex=1; ld_ex_mem=ld_mem_wb=1.
  - IF_WAIT: ld_pc=0; ld_if_id=1 with bub_if_id=1; ld_id_ex=ld_ex_mem=ld_mem_wb=1.
- flow_X = ~dcache_stall & ~flush_req.
  - flow_X must not depend on stall_X; no combinational loop is permitted.
  - When stall_X drops in the flow_X cycle, the class falls through to the lower priorities in that same cycle.
- flush_req held during MEM_WAIT is applied in the first cycle dcache_stall is low. MEM is frozen, so the request persists.
- FSM state register stall_class: RUN=0, IF_WAIT=1, HAZ=2, EX_WAIT=3, MEM_WAIT=4, FLUSH=5. It loads the current class every cycle.
- Watchdog counter:
  - Resets to 0 in any RUN or FLUSH cycle.
  - Otherwise increments, saturating at 2^WD_W-1.
  - stall_timeout sets on the edge where the count reaches WD_LIMIT and stays set until reset.
- Reset:
  - The outputs are combinational, so reset does not zero them: they follow the priority rules from the current inputs in every cycle, including reset cycles.
  - On the reset edge, stall_class, the watchdog counter and stall_timeout clear to 0.
  - In the first cycle after reset, stall_class=0 and stall_timeout=0.
  - Reset mid-stall clears the counter and stall_class immediately.
  - All combinational outputs respond in the same cycle as their inputs; there is no added latency.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined:
  - Adds output ports perf_ex_cycles [31:0] and perf_mem_cycles [31:0].
  - Each counts EX_WAIT / MEM_WAIT cycles respectively, wraps at 2^32 and clears on reset.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Only stall_X=1 for 5 cycles, then stall_X dropped in response to flow_X=1 -> during the stall, ld_pc=ld_if_id=ld_id_ex=0 and ld_ex_mem=1 with bub_ex_mem=1; flow_X=1 throughout; in the release cycle all ld=1; stall_class reads 3 then 0.
- stall_X=1 and dcache_stall=1 for 3 cycles -> all ld=0, flow_X=0; after dcache_stall=0, EX_WAIT outputs apply and flow_X=1.
- ex_valid=1, ex_is_load=1, ex_dr=3, id_use_sr2=1, id_sr2=3 -> exactly one HAZ cycle: ld_pc=0, bub_id_ex=1; next cycle (ex_is_load=0) class is RUN.
- flush_req=1 together with stall_X=1 and icache_stall=1 -> FLUSH outputs: all ld=1, three bubbles, kill_X=1, flow_X=0.
- WD_LIMIT=8, icache_stall held for 20 cycles -> stall_timeout rises at the edge where the count reaches 8; it stays 1 after icache_stall=0 until reset=1, and is 0 the cycle after the reset edge.
- With STALL_PERF_CNT_EN defined: 4 EX_WAIT cycles + 2 MEM_WAIT cycles -> perf_ex_cycles=4, perf_mem_cycles=2; reset -> both read 0.
